fifo_sync: RTL and testbench

- Synchronous first-word-fall-through FIFO. It is instantiated four times on the input side and four times on the output side of the 4-port arbiter.
- Supplies the empty and almost_full status the arbiter uses for its pop/push decisions.
- The head word is visible on data_out in the same cycle pop is asserted, so the arbiter's combinational mux captures it without extra latency.
- Overflow and underflow are detected and flagged; the offending operation is discarded.

---
 rtl/fifo_sync_if.sv | 25 ++
 rtl/fifo_sync.sv | 85 ++++++++
 tb/tb_fifo_sync.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fifo_sync_if.sv
// Handshake/data bundle between a fifo_sync instance and its user.
// slave = FIFO side, master = the logic pushing into / popping from it.
interface fifo_sync_if #(
  parameter int FIFO_WORD_SIZE = 10
);
  logic                      push;
  logic                      pop;
  logic [FIFO_WORD_SIZE-1:0] data_in;
  logic [FIFO_WORD_SIZE-1:0] data_out;
  logic                      empty;
  logic                      full;
  logic                      almost_full;
  logic                      almost_empty;
  logic                      error;

  modport slave (
    input  push, pop, data_in,
    output data_out, empty, full, almost_full, almost_empty, error
  );

  modport master (
    output push, pop, data_in,
    input  data_out, empty, full, almost_full, almost_empty, error
  );
endinterface

// File: rtl/fifo_sync.sv
// First-word-fall-through synchronous FIFO with occupancy flags and
// overflow/underflow error; define FIFO_ERROR_STICKY_EN to make error sticky.
module fifo_sync #(
  parameter int FIFO_WORD_SIZE   = 10,
  parameter int FIFO_DEPTH       = 8,
  parameter int PTR_SIZE         = 3,
  parameter int ALMOST_FULL_LVL  = 6,
  parameter int ALMOST_EMPTY_LVL = 2
) (
  input  logic        clk,
  input  logic        reset,
  fifo_sync_if.slave  bus
);

  localparam logic [PTR_SIZE:0]   DEPTH_C = (PTR_SIZE+1)'(FIFO_DEPTH);
  localparam logic [PTR_SIZE:0]   AF_C    = (PTR_SIZE+1)'(ALMOST_FULL_LVL);
  localparam logic [PTR_SIZE:0]   AE_C    = (PTR_SIZE+1)'(ALMOST_EMPTY_LVL);
  localparam logic [PTR_SIZE:0]   CNT_ONE = (PTR_SIZE+1)'(1);
  localparam logic [PTR_SIZE-1:0] PTR_ONE = PTR_SIZE'(1);

  logic [FIFO_WORD_SIZE-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_SIZE:0]   count_q, count_d;
  logic                error_q, error_d;

  logic is_empty, is_full;
  logic do_push, do_pop;
  logic overflow, underflow;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign do_pop    = bus.pop && !is_empty;
  assign do_push   = bus.push && (!is_full || do_pop);
  assign underflow = bus.pop && is_empty;
  assign overflow  = bus.push && !do_push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
`ifdef FIFO_ERROR_STICKY_EN
    error_d = error_q || overflow || underflow;
`else
    error_d = overflow || underflow;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  // Storage is never reset; a cleared count makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign bus.data_out     = is_empty ? '0 : mem_q[rd_ptr_q];
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.error        = error_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: scoreboard queue predicts data and flags.
module tb_fifo_sync;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_sync_if #(.FIFO_WORD_SIZE(10)) fif ();

  fifo_sync dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fif)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [9:0] sb [$];
  logic       sticky_exp = 1'b0;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic exp_err);
    int n;
    logic [9:0] head;
    n = sb.size();
    head = (n > 0) ? sb[0] : 10'h000;
    chk_bit ({tag, ".empty"},  fif.empty,        n == 0);
    chk_bit ({tag, ".full"},   fif.full,         n == 8);
    chk_bit ({tag, ".afull"},  fif.almost_full,  n >= 6);
    chk_bit ({tag, ".aempty"}, fif.almost_empty, n <= 2);
    chk_word({tag, ".dout"},   fif.data_out,     head);
    chk_bit ({tag, ".error"},  fif.error,        exp_err);
  endtask

  // One clocked operation; inputs applied 1ns after a rising edge.
  task automatic cycle(input string tag, input logic p, input logic q, input logic [9:0] d);
    logic do_pop, do_push, err;
    fif.push    = p;
    fif.pop     = q;
    fif.data_in = d;
    do_pop  = q && (sb.size() > 0);
    do_push = p && ((sb.size() < 8) || do_pop);
    err     = (q && (sb.size() == 0)) || (p && !do_push);
    if (do_pop) begin
      chk_word({tag, ".head"}, fif.data_out, sb[0]);
      void'(sb.pop_front());
    end
    if (do_push) sb.push_back(d);
    sticky_exp = sticky_exp | err;
    @(posedge clk);
    #1;
    fif.push = 1'b0;
    fif.pop  = 1'b0;
    $display("op %s push=%0b pop=%0b din=%03h -> dout=%03h cnt=%0d err=%0b",
             tag, p, q, d, fif.data_out, sb.size(), fif.error);
`ifdef FIFO_ERROR_STICKY_EN
    chk_state(tag, sticky_exp);
`else
    chk_state(tag, err);
`endif
  endtask

  initial begin
    fif.push    = 1'b1;
    fif.pop     = 1'b0;
    fif.data_in = 10'h1C3;

    // Reset held for two edges with push asserted: nothing may be written.
    repeat (2) @(posedge clk);
    #1;
    chk_state("rst_hold", 1'b0);
    fif.push = 1'b0;
    reset    = 1'b0;
    @(posedge clk);
    #1;
    chk_state("rst_rel", 1'b0);

    for (int i = 1; i <= 8; i++) cycle($sformatf("fill%0d", i), 1'b1, 1'b0, 10'(i));
    cycle("ovf", 1'b1, 1'b0, 10'h3FF);
    cycle("idle_full", 1'b0, 1'b0, 10'h000);
    cycle("full_pp", 1'b1, 1'b1, 10'h155);
    chk_word("full_pp.next", fif.data_out, 10'h002);
    for (int i = 0; i < 8; i++) cycle($sformatf("drain%0d", i), 1'b0, 1'b1, 10'h000);
    cycle("empty_pp", 1'b1, 1'b1, 10'h0AA);
    chk_word("empty_pp.dout", fif.data_out, 10'h0AA);
    cycle("pop_aa", 1'b0, 1'b1, 10'h000);

    // Interleaved traffic drives both pointers around the ring.
    for (int i = 0; i < 20; i++)
      cycle($sformatf("wrap%0d", i), (i % 2) == 0, (i % 2) == 1, 10'(10'h040 + i));
    for (int i = 0; i < 3; i++) cycle($sformatf("pre%0d", i), 1'b1, 1'b0, 10'(10'h100 + i));
    for (int i = 0; i < 10; i++) cycle($sformatf("pp%0d", i), 1'b1, 1'b1, 10'(10'h200 + i));
    for (int i = 0; i < 3; i++) cycle($sformatf("post%0d", i), 1'b0, 1'b1, 10'h000);

    // Underflow followed by legal traffic: pulse clears, sticky build holds.
    cycle("udf", 1'b0, 1'b1, 10'h000);
    for (int i = 0; i < 5; i++) begin
      cycle($sformatf("legal_push%0d", i), 1'b1, 1'b0, 10'(10'h300 + i));
      cycle($sformatf("legal_pop%0d", i), 1'b0, 1'b1, 10'h000);
    end

    // Asynchronous reset applied between edges during a burst.
    for (int i = 0; i < 4; i++) cycle($sformatf("burst%0d", i), 1'b1, 1'b0, 10'(10'h0F0 + i));
    #2;
    reset = 1'b1;
    sb.delete();
    sticky_exp = 1'b0;
    #1;
    chk_state("async_rst", 1'b0);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_state("post_rst", 1'b0);
    cycle("after_push", 1'b1, 1'b0, 10'h2D2);
    cycle("after_pop", 1'b0, 1'b1, 10'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
